// File: rtl/tmds_encoder_multi.sv
// N-lane TMDS (DVI 1.0) encoder: transition minimisation, DC balance, control symbols, per-lane inversion.
// Defining TMDS_GUARD_BAND_EN adds two delay stages and HDMI video guard-band insertion.
module tmds_encoder_multi #(
    parameter int                NUM_CH      = 3,
    parameter logic [NUM_CH-1:0] INVERT_MASK = {NUM_CH{1'b0}}
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         de_i,
    input  logic                                         hsync_i,
    input  logic                                         vsync_i,
    input  logic [((NUM_CH > 1) ? 2*(NUM_CH-1) : 1)-1:0] ctl_i,
    input  logic [8*NUM_CH-1:0]                          data_i,
    output logic [10*NUM_CH-1:0]                         sym_o,
    output logic                                         de_o
);
`ifdef TMDS_GUARD_BAND_EN
    localparam int PIPE = 3;
`else
    localparam int PIPE = 1;
`endif
    localparam logic [9:0] SYM_CTL00 = 10'h354;
    localparam logic [9:0] SYM_CTL01 = 10'h0AB;
    localparam logic [9:0] SYM_CTL10 = 10'h154;
    localparam logic [9:0] SYM_CTL11 = 10'h2AB;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = SYM_CTL00;
            2'b01:   s = SYM_CTL01;
            2'b10:   s = SYM_CTL10;
            2'b11:   s = SYM_CTL11;
            default: s = SYM_CTL00;
        endcase
        return s;
    endfunction

    logic de_r [PIPE];
    logic guard_s;

    // DE delay line shared by all lanes; de_o is the DE of the symbol being registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < PIPE; p++) de_r[p] <= 1'b0;
            de_o <= 1'b0;
        end else begin
            de_r[0] <= de_i;
            for (int p = 1; p < PIPE; p++) de_r[p] <= de_r[p-1];
            de_o <= de_r[PIPE-1];
        end
    end

`ifdef TMDS_GUARD_BAND_EN
    // Video is one or two slots behind the control symbol about to be sent
    assign guard_s = de_r[0] | de_r[1];
`else
    assign guard_s = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        localparam logic [9:0] GUARD_SYM = (k == 1) ? 10'h133 : 10'h2CC;

        logic [1:0]        ctl_in_s;
        logic [7:0]        d_s;
        logic [8:0]        qm_s;
        logic [3:0]        n1_s;
        logic [8:0]        qm_r  [PIPE];
        logic [3:0]        n1_r  [PIPE];
        logic [3:0]        n0_r  [PIPE];
        logic [1:0]        ctl_r [PIPE];
        logic [8:0]        qm_t_s;
        logic [3:0]        n1_t_s;
        logic [3:0]        n0_t_s;
        logic signed [5:0] diff_s;
        logic signed [5:0] cnt_s;
        logic signed [5:0] cnt_r;
        logic [9:0]        sym_s;
        logic [9:0]        sym_r;

        if (k == 0) begin : g_ctl0
            assign ctl_in_s = {vsync_i, hsync_i};
        end else begin : g_ctln
            assign ctl_in_s = ctl_i[2*k-1 -: 2];
        end
        assign d_s = data_i[8*k +: 8];

        // Stage 1: transition minimisation, XNOR chain when the byte is one-heavy
        always_comb begin
            qm_s    = 9'd0;
            qm_s[0] = d_s[0];
            if ((ones8(d_s) > 4'd4) || ((ones8(d_s) == 4'd4) && (d_s[0] == 1'b0))) begin
                for (int i = 1; i < 8; i++) qm_s[i] = ~(qm_s[i-1] ^ d_s[i]);
                qm_s[8] = 1'b0;
            end else begin
                for (int i = 1; i < 8; i++) qm_s[i] = qm_s[i-1] ^ d_s[i];
                qm_s[8] = 1'b1;
            end
            n1_s = ones8(qm_s[7:0]);
        end

        // q_m pipeline with its ones/zeros counts and the lane's control bits
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int p = 0; p < PIPE; p++) begin
                    qm_r[p]  <= 9'd0;
                    n1_r[p]  <= 4'd0;
                    n0_r[p]  <= 4'd0;
                    ctl_r[p] <= 2'b00;
                end
            end else begin
                qm_r[0]  <= qm_s;
                n1_r[0]  <= n1_s;
                n0_r[0]  <= 4'd8 - n1_s;
                ctl_r[0] <= ctl_in_s;
                for (int p = 1; p < PIPE; p++) begin
                    qm_r[p]  <= qm_r[p-1];
                    n1_r[p]  <= n1_r[p-1];
                    n0_r[p]  <= n0_r[p-1];
                    ctl_r[p] <= ctl_r[p-1];
                end
            end
        end

        assign qm_t_s = qm_r[PIPE-1];
        assign n1_t_s = n1_r[PIPE-1];
        assign n0_t_s = n0_r[PIPE-1];
        assign diff_s = $signed({2'b00, n1_t_s}) - $signed({2'b00, n0_t_s});

        // Stage 2: DC balance against the running disparity, or control/guard symbol
        always_comb begin
            sym_s = SYM_CTL00;
            cnt_s = cnt_r;
            if (!de_r[PIPE-1]) begin
                cnt_s = 6'sd0;
                if (guard_s) begin
                    sym_s = GUARD_SYM;
                end else begin
                    sym_s = ctl_sym(ctl_r[PIPE-1]);
                end
            end else if ((cnt_r == 6'sd0) || (n1_t_s == n0_t_s)) begin
                sym_s = {~qm_t_s[8], qm_t_s[8], (qm_t_s[8] ? qm_t_s[7:0] : ~qm_t_s[7:0])};
                cnt_s = qm_t_s[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
            end else if (((cnt_r > 6'sd0) && (n1_t_s > n0_t_s)) ||
                         ((cnt_r < 6'sd0) && (n0_t_s > n1_t_s))) begin
                sym_s = {1'b1, qm_t_s[8], ~qm_t_s[7:0]};
                cnt_s = cnt_r + (qm_t_s[8] ? 6'sd2 : 6'sd0) - diff_s;
            end else begin
                sym_s = {1'b0, qm_t_s[8], qm_t_s[7:0]};
                cnt_s = cnt_r - (qm_t_s[8] ? 6'sd0 : 6'sd2) + diff_s;
            end
        end

        // Output register with board-pair polarity applied
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_r <= 6'sd0;
                sym_r <= SYM_CTL00 ^ {10{INVERT_MASK[k]}};
            end else begin
                cnt_r <= cnt_s;
                sym_r <= sym_s ^ {10{INVERT_MASK[k]}};
            end
        end

        assign sym_o[10*k +: 10] = sym_r;
    end
endmodule
